mem_access_stage: RTL and testbench

//  Memory stage directly downstream of execute. Consumes execute's aluout
//  (result / effective address), rs2_value (store data), funct3, opcode and rd.

---
 rtl/mem_access_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/gnt/rvalid bus,
// aligns and extends load data, and retires one result per instruction to writeback.
module mem_access_stage #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_aluout,
  input  logic [XLEN-1:0] ex_rs2_value,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exc,
  output logic [1:0]      wb_exc_code
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {EXC_NONE, EXC_MISALIGN, EXC_FUNCT3, EXC_TIMEOUT} exc_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic            is_load, is_store, is_mem, f3_illegal, misaligned;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, lane, load_data;

  assign ex_ready = (state_q == ST_IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    is_load    = (ex_opcode == OP_LOAD);
    is_store   = (ex_opcode == OP_STORE);
    is_mem     = is_load || is_store;
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = ex_rs2_value;
    if (is_load)       f3_illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    else if (is_store) f3_illegal = (ex_funct3 > 3'b010);

    // funct3[1:0] encodes access size for both loads and stores.
    case (ex_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ex_aluout[1:0];
        wdata_d = {4{ex_rs2_value[7:0]}};
      end
      2'b01: begin
        misaligned = ex_aluout[0];
        be_d       = 4'b0011 << ex_aluout[1:0];
        wdata_d    = {2{ex_rs2_value[15:0]}};
      end
      default: misaligned = |ex_aluout[1:0];
    endcase

    lane = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_exc      <= 1'b0;
      wb_exc_code <= EXC_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wb_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_valid) begin
            wb_rd       <= ex_rd;
            wb_data     <= ex_aluout;
            wb_we       <= 1'b0;
            wb_exc      <= 1'b0;
            wb_exc_code <= EXC_NONE;
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != 5'd0) && (ex_opcode != OP_BRANCH);
            end else if (f3_illegal) begin
              wb_valid    <= 1'b1;
              wb_exc      <= 1'b1;
              wb_exc_code <= EXC_FUNCT3;
            end else if (misaligned) begin
              wb_valid    <= 1'b1;
              wb_exc      <= 1'b1;
              wb_exc_code <= EXC_MISALIGN;
            end else begin
              state_q    <= ST_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {ex_aluout[XLEN-1:2], 2'b00};
              dmem_be    <= be_d;
              dmem_wdata <= wdata_d;
              is_load_q  <= is_load;
              funct3_q   <= ex_funct3;
              off_q      <= ex_aluout[1:0];
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (is_load_q) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
            end else begin
              state_q  <= ST_IDLE;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Data arriving on the final allowed cycle still beats the timeout.
          if (dmem_rvalid) begin
            state_q  <= ST_IDLE;
            wb_valid <= 1'b1;
            wb_we    <= (wb_rd != 5'd0);
            wb_data  <= load_data;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_IDLE;
            wb_valid    <= 1'b1;
            wb_we       <= 1'b0;
            wb_exc      <= 1'b1;
            wb_exc_code <= EXC_TIMEOUT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instruction streams scored against a queue-based behavioural model.
module tb_mem_access_stage;

  localparam int TO = 16;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_aluout, ex_rs2_value;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc_code;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_aluout(ex_aluout), .ex_rs2_value(ex_rs2_value),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exc(wb_exc), .wb_exc_code(wb_exc_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    logic        exc;
    logic [1:0]  code;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          req_cycles, wait_cycles;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] v;
    int          nbits;
    if (f3[1:0] == 2'd2) return word;
    nbits = 8 << f3[1:0];
    v = word >> (8 * int'(off));
    v = v & ((32'd1 << nbits) - 32'd1);
    if (!f3[2] && v[nbits-1]) v = v - (32'd1 << nbits);
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] off, input int nb);
    logic [3:0] be;
    int         o;
    o = int'(off);
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + nb);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int nb);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % nb) +: 8];
    return wd;
  endfunction

  // Scoreboard: every retire must match the oldest expectation, on its predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        check("wb_spurious", 32'(wb_valid), 0);
      end else if (wb_valid) begin
        cur = exp_q.pop_front();
        check("wb_cycle", cyc, cur.cyc);
        check("wb_we", 32'(wb_we), 32'(cur.we));
        check("wb_rd", 32'(wb_rd), 32'(cur.rd));
        check("wb_exc", 32'(wb_exc), 32'(cur.exc));
        check("wb_exc_code", 32'(wb_exc_code), 32'(cur.code));
        if (cur.chk_data) check("wb_data", wb_data, cur.data);
      end else if (cyc > exp_q[0].cyc) begin
        check("wb_missing", 32'(wb_valid), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Issues one instruction and services the bus; returns on the negedge where its retire is visible.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rs2,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    exp_t e;
    bit   is_ld, is_st, fast, done;
    int   nb;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    nb    = 1 << f3[1:0];
    e.cyc = cyc + 1; e.we = 1'b0; e.rd = rd; e.data = alu; e.chk_data = 1'b1;
    e.exc = 1'b0; e.code = 2'd0;
    fast  = 1'b1;
    if (!is_ld && !is_st) begin
      e.we = (rd != 5'd0) && (op != OP_BRANCH);
    end else if (is_ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 > 3'd2)) begin
      e.exc = 1'b1; e.code = 2'd2; e.chk_data = 1'b0;
    end else if ((alu % nb) != 0) begin
      e.exc = 1'b1; e.code = 2'd1;
    end else begin
      fast = 1'b0;
    end
    req_cycles = 0;
    wait_cycles = 0;
    check("ready_idle", 32'(ex_ready), 1);
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_rd = rd; ex_aluout = alu; ex_rs2_value = rs2;
    if (fast) exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0; ex_opcode = 7'($urandom); ex_funct3 = 3'($urandom); ex_rd = 5'($urandom);
    ex_aluout = $urandom; ex_rs2_value = $urandom;
    if (fast) begin
      check("no_req", 32'(dmem_req), 0);
      return;
    end
    for (int k = 0; k <= gdly; k++) begin
      req_cycles++;
      check("req_high", 32'(dmem_req), 1);
      check("req_we", 32'(dmem_we), 32'(is_st));
      check("req_addr", dmem_addr, alu & ~32'h3);
      check("req_be", 32'(dmem_be), 32'(model_be(alu[1:0], nb)));
      if (is_st) check("req_wdata", dmem_wdata, model_wdata(rs2, nb));
      check("ready_req", 32'(ex_ready), 0);
      last_be = dmem_be; last_addr = dmem_addr; last_wdata = dmem_wdata;
      dmem_gnt = (k == gdly);
      if (k == gdly && is_st) begin
        e.cyc = cyc + 1; e.chk_data = 1'b0;
        exp_q.push_back(e);
      end
      @(posedge clk); @(negedge clk);
      dmem_gnt = 1'b0;
    end
    if (is_st) return;
    done = 1'b0;
    for (int w = 0; w < TO && !done; w++) begin
      wait_cycles++;
      check("wait_req_low", 32'(dmem_req), 0);
      check("ready_wait", 32'(ex_ready), 0);
      if (w == rdly) begin
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        e.data = model_load(rdata, alu[1:0], f3); e.we = (rd != 5'd0); e.cyc = cyc + 1;
        exp_q.push_back(e);
        done = 1'b1;
      end else if (w == TO - 1) begin
        e.exc = 1'b1; e.code = 2'd3; e.chk_data = 1'b0; e.cyc = cyc + 1;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    end
  endtask

  task automatic stray_rvalid(input string name);
    dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    dmem_rvalid = 1'b0;
    check(name, 32'(wb_valid), 0);
    check({name, "_ready"}, 32'(ex_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    int          kind, gdly, rdly, nb;
    logic [6:0]  nonmem_ops [4];
    nonmem_ops = '{OP_ALU, OP_IMM, OP_LUI, OP_BRANCH};

    ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_rd = '0; ex_aluout = '0; ex_rs2_value = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_exc", {29'd0, wb_exc, wb_exc_code}, 0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(ex_ready), 1);
    @(negedge clk);

    run_op(OP_ALU, 3'd0, 5'd5, 32'h3000, 32'h0, 0, 0, 32'h0);
    check("add_data", wb_data, 32'h3000);
    check("add_we", 32'(wb_we), 1);
    check("add_ready", 32'(ex_ready), 1);

    run_op(OP_LOAD, 3'b000, 5'd3, 32'h102, 32'h0, 0, 1, 32'h80FF7F00);
    check("lb_be", 32'(last_be), 32'h4);
    check("lb_addr", last_addr, 32'h100);
    check("lb_data", wb_data, 32'hFFFFFFFF);

    run_op(OP_LOAD, 3'b100, 5'd3, 32'h102, 32'h0, 1, 0, 32'h80FF7F00);
    check("lbu_data", wb_data, 32'h000000FF);

    run_op(OP_STORE, 3'b001, 5'd0, 32'h2002, 32'h1234ABCD, 2, 0, 32'h0);
    check("sh_req_cycles", req_cycles, 3);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'hABCDABCD);
    check("sh_retire", {30'd0, wb_valid, wb_we}, 32'h2);

    run_op(OP_LOAD, 3'b010, 5'd7, 32'h1001, 32'h0, 0, 0, 32'h0);
    check("lw_mis_req_cycles", req_cycles, 0);
    check("lw_mis_exc", {29'd0, wb_exc, wb_exc_code}, 32'h5);
    check("lw_mis_data", wb_data, 32'h1001);

    run_op(OP_LOAD, 3'b010, 5'd8, 32'h4000, 32'h0, 0, 99, 32'h0);
    check("lw_to_wait_cycles", wait_cycles, 16);
    check("lw_to_exc", {29'd0, wb_exc, wb_exc_code}, 32'h7);
    stray_rvalid("to_stray");

    run_op(OP_LOAD, 3'b101, 5'd9, 32'h5002, 32'h0, 0, 15, 32'hBEEF1234);
    check("lhu_last_cycle_data", wb_data, 32'h0000BEEF);
    check("lhu_last_cycle_exc", 32'(wb_exc), 0);

    run_op(OP_STORE, 3'b011, 5'd2, 32'h6000, 32'h0, 0, 0, 32'h0);
    check("sd_illegal_code", 32'(wb_exc_code), 2);
    run_op(OP_IMM, 3'd0, 5'd0, 32'h11, 32'h0, 0, 0, 32'h0);
    check("rd0_we", 32'(wb_we), 0);
    run_op(OP_BRANCH, 3'd0, 5'd4, 32'h22, 32'h0, 0, 0, 32'h0);
    check("branch_we", 32'(wb_we), 0);
    run_op(OP_LUI, 3'd0, 5'd6, 32'h12345000, 32'h0, 0, 0, 32'h0);
    check("lui_data", wb_data, 32'h12345000);

    // Reset while a store waits for grant.
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = OP_STORE; ex_funct3 = 3'b010; ex_rd = 5'd0;
    ex_aluout = 32'h7000; ex_rs2_value = 32'h55;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    check("req_before_rst", 32'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_req_drop", 32'(dmem_req), 0);
    check("rst_req_wb", 32'(wb_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_req_ready", 32'(ex_ready), 1);

    // Reset while a load waits for data.
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_funct3 = 3'b010; ex_rd = 5'd4; ex_aluout = 32'h8000;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 1'b0;
    check("wait_before_rst", 32'(ex_ready), 0);
    #2 rst_n = 1'b0;
    #1 check("rst_wait_req", 32'(dmem_req), 0);
    check("rst_wait_wb", 32'(wb_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_wait_ready", 32'(ex_ready), 1);
    @(negedge clk);
    stray_rvalid("rst_late_rvalid");

    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 9);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      alu  = $urandom;
      gdly = $urandom_range(0, 3);
      rdly = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      if (kind < 4) begin
        op = nonmem_ops[$urandom_range(0, 3)];
        f3 = 3'($urandom);
      end else begin
        op = (kind < 7) ? OP_LOAD : OP_STORE;
        f3 = (op == OP_LOAD) ? 3'($urandom) : 3'($urandom_range(0, 3));
        nb = 1 << f3[1:0];
        if ($urandom_range(0, 3) != 0) alu = alu & ~(32'(nb) - 32'd1);
      end
      run_op(op, f3, rd, alu, $urandom, gdly, rdly, $urandom);
      if (op == OP_LOAD && rdly >= TO) stray_rvalid("rand_stray");
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
